// File: rtl/motion_pkg.sv
// Shared types and default geometry/threshold for the motion mask block.
package motion_pkg;

  typedef enum logic {S_READ, S_WRITE} state_e;

  localparam int unsigned DefWidth     = 720;
  localparam int unsigned DefHeight    = 540;
  localparam int unsigned DefThreshold = 50;

endpackage

// File: rtl/motion_mask.sv
// Compares current and background gray pixels from paired FWFT FIFOs and writes a
// binary motion mask, counting motion pixels per frame.
module motion_mask
  import motion_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned HEIGHT    = DefHeight,
  parameter int unsigned THRESHOLD = DefThreshold
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        base_empty,
  input  logic [7:0]  base_dout,
  output logic        base_rd_en,
  input  logic        img_empty,
  input  logic [7:0]  img_dout,
  output logic        img_rd_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [7:0]  out_din,
  output logic        frame_done,
  output logic [19:0] motion_count
);

  localparam int unsigned Pixels = WIDTH * HEIGHT;
  localparam int unsigned PixW   = (Pixels > 1) ? $clog2(Pixels) : 1;
  localparam logic [PixW-1:0] LastPix = PixW'(Pixels - 1);

  state_e          state_q, state_d;
  logic [7:0]      mask_q, mask_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [19:0]     run_q, run_d;
  logic [19:0]     mcount_q, mcount_d;
  logic            done_q, done_d;

  logic [8:0] diff;
  logic [8:0] abs_diff;
  logic       motion;
  logic       pop;
  logic       push;
  logic       hit;

  // 9-bit difference keeps the sign so the magnitude covers the full 0..255 range.
  assign diff     = {1'b0, img_dout} - {1'b0, base_dout};
  assign abs_diff = diff[8] ? (~diff + 9'd1) : diff;
  assign motion   = abs_diff > 9'(THRESHOLD);

  // Gated by reset so no FIFO is touched while reset is held.
  assign pop  = (state_q == S_READ) && !base_empty && !img_empty && !reset;
  assign push = (state_q == S_WRITE) && !out_full && !reset;
  assign hit  = (mask_q == 8'hFF);

  assign base_rd_en   = pop;
  assign img_rd_en    = pop;
  assign out_wr_en    = push;
  assign out_din      = push ? mask_q : 8'h00;
  assign frame_done   = done_q;
  assign motion_count = mcount_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pix_d    = pix_q;
    run_d    = run_q;
    mcount_d = mcount_q;
    done_d   = 1'b0;
    if (pop) begin
      mask_d  = motion ? 8'hFF : 8'h00;
      state_d = S_WRITE;
    end
    if (push) begin
      state_d = S_READ;
      if (pix_q == LastPix) begin
        pix_d    = '0;
        run_d    = '0;
        mcount_d = run_q + 20'(hit);
        done_d   = 1'b1;
      end else begin
        pix_d = pix_q + PixW'(1);
        run_d = run_q + 20'(hit);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_READ;
      mask_q   <= 8'h00;
      pix_q    <= '0;
      run_q    <= '0;
      mcount_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pix_q    <= pix_d;
      run_q    <= run_d;
      mcount_q <= mcount_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_motion_mask.sv
// Directed bench for motion_mask with a 4x2 frame: vector table plus stall and reset sequences.
module tb_motion_mask;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        base_empty = 1'b1;
  logic [7:0]  base_dout = 8'h00;
  logic        base_rd_en;
  logic        img_empty = 1'b1;
  logic [7:0]  img_dout = 8'h00;
  logic        img_rd_en;
  logic        out_full = 1'b0;
  logic        out_wr_en;
  logic [7:0]  out_din;
  logic        frame_done;
  logic [19:0] motion_count;

  motion_mask #(
    .WIDTH    (4),
    .HEIGHT   (2),
    .THRESHOLD(50)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .base_empty  (base_empty),
    .base_dout   (base_dout),
    .base_rd_en  (base_rd_en),
    .img_empty   (img_empty),
    .img_dout    (img_dout),
    .img_rd_en   (img_rd_en),
    .out_full    (out_full),
    .out_wr_en   (out_wr_en),
    .out_din     (out_din),
    .frame_done  (frame_done),
    .motion_count(motion_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] base;
    logic [7:0] img;
    logic [7:0] mask;
  } vec_t;

  vec_t vecs[8];
  vec_t vecs2[7];

  int checks = 0;
  int passed = 0;

  // Reference frame bookkeeping for a 4x2 frame.
  int pix_m = 0;
  int run_m = 0;
  int mc_exp = 0;
  logic pending_fd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_write(input logic [7:0] m);
    int h;
    h = (m == 8'hFF) ? 1 : 0;
    if (pix_m == 7) begin
      mc_exp     = run_m + h;
      run_m      = 0;
      pix_m      = 0;
      pending_fd = 1'b1;
    end else begin
      run_m = run_m + h;
      pix_m = pix_m + 1;
    end
  endtask

  task automatic do_pixel(input logic [7:0] b, input logic [7:0] i, input logic [7:0] m);
    @(negedge clock);
    base_empty = 1'b0;
    img_empty  = 1'b0;
    base_dout  = b;
    img_dout   = i;
    out_full   = 1'b0;
    #1;
    chk("pop_enables", {base_rd_en, img_rd_en, out_wr_en}, 3'b110);
    chk("din_idle", out_din, 8'h00);
    chk("frame_done", frame_done, pending_fd);
    chk("motion_count", motion_count, mc_exp);
    pending_fd = 1'b0;
    @(negedge clock);
    base_empty = 1'b1;
    img_empty  = 1'b1;
    #1;
    chk("write_enables", {base_rd_en, img_rd_en, out_wr_en}, 3'b001);
    chk("mask", out_din, m);
    chk("frame_done_low", frame_done, 1'b0);
    model_write(m);
  endtask

  task automatic idle_check();
    @(negedge clock);
    base_empty = 1'b1;
    img_empty  = 1'b1;
    #1;
    chk("idle_frame_done", frame_done, pending_fd);
    chk("idle_motion_count", motion_count, mc_exp);
    chk("idle_enables", {base_rd_en, img_rd_en, out_wr_en}, 3'b000);
    pending_fd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd100, 8'd151, 8'hFF};
    vecs[1] = '{8'd100, 8'd150, 8'h00};
    vecs[2] = '{8'd200, 8'd149, 8'hFF};
    vecs[3] = '{8'd149, 8'd200, 8'hFF};
    vecs[4] = '{8'd0,   8'd255, 8'hFF};
    vecs[5] = '{8'd255, 8'd0,   8'hFF};
    vecs[6] = '{8'd10,  8'd10,  8'h00};
    vecs[7] = '{8'd60,  8'd10,  8'h00};

    vecs2[0] = '{8'd0,   8'd51,  8'hFF};
    vecs2[1] = '{8'd51,  8'd0,   8'hFF};
    vecs2[2] = '{8'd0,   8'd50,  8'h00};
    vecs2[3] = '{8'd128, 8'd128, 8'h00};
    vecs2[4] = '{8'd77,  8'd30,  8'h00};
    vecs2[5] = '{8'd200, 8'd250, 8'h00};
    vecs2[6] = '{8'd250, 8'd200, 8'h00};

    // Reset state, with FIFOs non-empty to show enables stay low.
    base_empty = 1'b0;
    img_empty  = 1'b0;
    #2;
    chk("rst_enables", {base_rd_en, img_rd_en, out_wr_en}, 3'b000);
    chk("rst_din", out_din, 8'h00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_motion_count", motion_count, 20'd0);
    @(negedge clock);
    base_empty = 1'b1;
    img_empty  = 1'b1;
    reset      = 1'b0;

    // Frame 1: five motion pixels.
    for (int k = 0; k < 8; k++) do_pixel(vecs[k].base, vecs[k].img, vecs[k].mask);
    idle_check();

    // Only the background FIFO has data: nothing may pop.
    @(negedge clock);
    base_empty = 1'b0;
    img_empty  = 1'b1;
    base_dout  = 8'd30;
    img_dout   = 8'd90;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("single_fifo_no_pop", {base_rd_en, img_rd_en, out_wr_en}, 3'b000);
      @(negedge clock);
    end
    img_empty = 1'b0;
    #1;
    chk("paired_pop", {base_rd_en, img_rd_en, out_wr_en}, 3'b110);
    @(negedge clock);
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("full_hold", {base_rd_en, img_rd_en, out_wr_en}, 3'b000);
      chk("full_din", out_din, 8'h00);
      @(negedge clock);
    end
    out_full   = 1'b0;
    base_empty = 1'b1;
    img_empty  = 1'b1;
    #1;
    chk("held_write", {base_rd_en, img_rd_en, out_wr_en}, 3'b001);
    chk("held_mask", out_din, 8'hFF);
    model_write(8'hFF);

    // Frame 2: stalled pixel plus two more motion pixels.
    for (int k = 0; k < 7; k++) do_pixel(vecs2[k].base, vecs2[k].img, vecs2[k].mask);
    idle_check();
    chk("frame2_count", motion_count, 20'd3);

    // Reset mid-frame after three pixels.
    for (int k = 0; k < 3; k++) do_pixel(vecs[k].base, vecs[k].img, vecs[k].mask);
    @(negedge clock);
    reset      = 1'b1;
    base_empty = 1'b0;
    img_empty  = 1'b0;
    #1;
    chk("midrst_enables", {base_rd_en, img_rd_en, out_wr_en}, 3'b000);
    chk("midrst_din", out_din, 8'h00);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_motion_count", motion_count, 20'd0);
    @(negedge clock);
    reset      = 1'b0;
    base_empty = 1'b1;
    img_empty  = 1'b1;
    pix_m      = 0;
    run_m      = 0;
    mc_exp     = 0;
    pending_fd = 1'b0;

    for (int k = 0; k < 8; k++) do_pixel(vecs[k].base, vecs[k].img, vecs[k].mask);
    idle_check();
    chk("post_rst_count", motion_count, 20'd5);
    idle_check();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/motion_mask.md
MOTION_MASK -- requirements
Module: motion_mask

Interface
REQ-001 SHALL have parameter WIDTH, default 720: pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 540: lines per frame.
REQ-003 SHALL have parameter THRESHOLD, default 50: 8-bit unsigned motion threshold.
REQ-004 SHALL have port clock  in  1: rising-edge clock.
REQ-005 SHALL have port reset  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port base_empty  in  1: background-gray FIFO empty.
REQ-007 SHALL have port base_dout  in  8: background gray pixel, valid while base_empty=0 (FWFT).
REQ-008 SHALL have port base_rd_en  out  1: pop background FIFO.
REQ-009 SHALL have port img_empty  in  1: current-frame gray FIFO empty.
REQ-010 SHALL have port img_dout  in  8: current gray pixel, valid while img_empty=0 (FWFT).
REQ-011 SHALL have port img_rd_en  out  1: pop current FIFO.
REQ-012 SHALL have port out_full  in  1: mask FIFO full.
REQ-013 SHALL have port out_wr_en  out  1: push mask pixel.
REQ-014 SHALL have port out_din  out  8: mask pixel, 8'hFF motion / 8'h00 none.
REQ-015 SHALL have port frame_done  out  1: one-cycle pulse after last pixel of frame written.
REQ-016 SHALL have port motion_count  out  20: motion-pixel count of last completed frame.

Function
REQ-017 SHALL implement a two-state FSM: S_READ, S_WRITE.
REQ-018 In S_READ, only when base_empty=0 and img_empty=0, SHALL assert base_rd_en and img_rd_en together for one cycle, register mask, go to S_WRITE.
REQ-019 SHALL never pop one input FIFO without the other; a single non-empty FIFO causes no pop.
REQ-020 Mask SHALL be 8'hFF iff |img_dout - base_dout| > THRESHOLD (9-bit signed-safe difference, strict greater); equal to THRESHOLD yields 8'h00.
REQ-021 In S_WRITE, only when out_full=0, SHALL assert out_wr_en with out_din = registered mask, return to S_READ.
REQ-022 out_din SHALL be 8'h00 whenever out_wr_en=0.
REQ-023 While out_full=1 in S_WRITE, SHALL hold state and mask, no pops.
REQ-024 Minimum latency: write in cycle after pop; throughput 1 pixel per 2 cycles.
REQ-025 SHALL keep pixel counter (0..WIDTH*HEIGHT-1) and running motion counter, both incremented on each write (motion only when mask=8'hFF).
REQ-026 On write of pixel index WIDTH*HEIGHT-1: pulse frame_done next cycle, load motion_count with final running count (including that pixel), clear both counters to 0.
REQ-027 motion_count SHALL hold its value until next frame completion.

Reset
REQ-028 On reset: state S_READ, mask 8'h00, counters 0, motion_count 0, frame_done 0, all rd/wr enables 0.
REQ-029 Reset mid-frame SHALL abandon the partial frame; the next pixel after reset counts as index 0.

Structure
REQ-030 Package motion_pkg SHALL hold the state typedef and default WIDTH/HEIGHT/THRESHOLD constants.
REQ-031 No sub-module; abs-diff/compare SHALL be inline combinational logic.

Verification
REQ-032 base=100, img=151 -> out_din=8'hFF; base=100, img=150 -> 8'h00; base=200, img=149 -> 8'hFF.
REQ-033 base_empty=0, img_empty=1 for 10 cycles -> no rd_en, no out_wr_en; then img_empty=0 -> single paired pop.
REQ-034 out_full=1 for 5 cycles in S_WRITE -> no pops, out_din 0; out_full=0 -> one write of held mask.
REQ-035 WIDTH=4, HEIGHT=2, 3 motion pixels -> frame_done one pulse after 8th write, motion_count=3, counters restart.
REQ-036 Reset asserted after 3 pixels of 8 -> outputs zeroed; 8 new pixels -> frame_done after 8th write.
